buffer_write_arbiter: RTL and testbench

Round-robin, packet-atomic write arbiter that shares one flit FIFO among `NUM_REQ` router input requesters. It sits in front of the shared buffer on the write side. Each cycle it selects at most one requester and drives the buffer's data/`produce` inputs. Once a multi-flit packet has started, the arbiter holds the grant until that packet's last flit is written, so flits from different packets never interleave. A watchdog releases the lock if the owning requester stalls mid-packet.

---
 rtl/router_buf_pkg.sv | 19 +
 rtl/rr_picker.sv | 33 +++
 rtl/buffer_write_arbiter.sv | 126 ++++++++++++
 tb/tb_buffer_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/router_buf_pkg.sv
// Shared types and constants for the router input buffer and its write-side arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package router_buf_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Flit width used by the shared buffer and its arbiters.
    localparam int BUF_FLIT_W = 64;

    // Index width for n requesters; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or cyclically above ptr.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is accepted.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   pick,
    output logic               any
);

    logic [IDX_W:0] idx;

    // Scan offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (idx >= (IDX_W + 1)'(NUM_REQ)) begin
                idx = idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[idx[IDX_W-1:0]]) begin
                pick = idx[IDX_W-1:0];
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_write_arbiter.sv
// Packet-atomic round-robin arbiter sharing one flit FIFO among NUM_REQ requesters.
// Latency: zero cycles from request to buf_produce; state updates on the clk edge.
// Backpressure: buf_full drops the selected requester's ready; no write while full.
module buffer_write_arbiter
    import router_buf_pkg::*;
#(
    parameter int   NUM_REQ   = 4,
    parameter int   FLIT_W    = BUF_FLIT_W,
    parameter int   STALL_MAX = 255,
    localparam int  IDX_W     = req_idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*FLIT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      buf_full,
    output logic [FLIT_W-1:0]         buf_in,
    output logic                      buf_produce,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      grant_valid,
    output logic                      stall_err
);

    localparam int               CNT_W     = $clog2(STALL_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    // The counter value seen on the final idle cycle before release.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STALL_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [CNT_W-1:0] stall_cnt, cnt_nxt;
    logic             serr_nxt;
    logic [IDX_W-1:0] cand;
    logic             any_vld;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (cand),
        .any  (any_vld)
    );

    // Grant selection: the owner holds the grant while locked, otherwise the round-robin candidate.
    always_comb begin
        grant_valid = (state == LOCKED) | any_vld;
        grant_id    = (state == LOCKED) ? owner : cand;
        req_ready   = '0;
        if (grant_valid) begin
            req_ready[grant_id] = ~buf_full;
        end
        buf_produce = req_valid[grant_id] & req_ready[grant_id];
    end

    // The granted flit is always presented; buf_produce alone qualifies it.
    assign buf_in = req_data[int'(grant_id)*FLIT_W +: FLIT_W];

    // Next-state: lock on a non-last flit, release on last flit or watchdog expiry.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = stall_cnt;
        serr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (buf_produce) begin
                    if (req_last[cand]) begin
                        rr_nxt = idx_inc(cand);
                    end else begin
                        state_nxt = LOCKED;
                        owner_nxt = cand;
                        cnt_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                if (buf_produce) begin
                    cnt_nxt = '0;
                    if (req_last[owner]) begin
                        state_nxt = IDLE;
                        rr_nxt    = idx_inc(owner);
                    end
                end else if (!req_valid[owner]) begin
                    // Owner idle: count toward release. Owner valid but blocked by buf_full holds the count.
                    if (stall_cnt >= CNT_LIMIT) begin
                        state_nxt = IDLE;
                        rr_nxt    = idx_inc(owner);
                        cnt_nxt   = '0;
                        serr_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = stall_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointer, counter and registered stall pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            stall_cnt <= cnt_nxt;
            stall_err <= serr_nxt;
        end
    end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter: table of per-cycle vectors plus a watchdog sequence.
// Latency: checks combinational outputs mid-cycle and registered stall_err one cycle later.
// Backpressure: exercises buf_full both while idle and mid-packet.
module tb_buffer_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SM = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           buf_full;
    logic [W-1:0]   buf_in;
    logic           buf_produce;
    logic [1:0]     grant_id;
    logic           grant_valid;
    logic           stall_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    buffer_write_arbiter #(
        .NUM_REQ   (N),
        .FLIT_W    (W),
        .STALL_MAX (SM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .buf_full    (buf_full),
        .buf_in      (buf_in),
        .buf_produce (buf_produce),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .stall_err   (stall_err)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic       full;
        logic [3:0] rdy;
        logic       prod;
        logic       gv;
        logic [1:0] gid;
        logic       serr;
        logic       chk_cnt;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic f, input logic [3:0] rdy, input logic prod,
                                input logic gv, input logic [1:0] gid, input logic serr,
                                input logic chk_cnt, input logic [2:0] cnt);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.full = f; t.rdy = rdy; t.prod = prod;
        t.gv = gv; t.gid = gid; t.serr = serr; t.chk_cnt = chk_cnt; t.cnt = cnt;
        return t;
    endfunction

    function automatic logic [W-1:0] flit(input int k, input int i);
        return W'(k * 256 + i * 16 + 5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic r, input logic [3:0] v,
                         input logic [3:0] l, input logic f);
        rst       = r;
        req_valid = v;
        req_last  = l;
        buf_full  = f;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = flit(k, i);
        end
    endtask

    task automatic check_row(input int k, input vec_t t);
        check($sformatf("row%0d ready", k), 32'(req_ready), 32'(t.rdy));
        check($sformatf("row%0d produce", k), 32'(buf_produce), 32'(t.prod));
        check($sformatf("row%0d grant_valid", k), 32'(grant_valid), 32'(t.gv));
        if (t.gv) check($sformatf("row%0d grant_id", k), 32'(grant_id), 32'(t.gid));
        if (t.prod) check($sformatf("row%0d buf_in", k), 32'(buf_in), 32'(flit(k, int'(t.gid))));
        check($sformatf("row%0d stall_err", k), 32'(stall_err), 32'(t.serr));
        if (t.chk_cnt) check($sformatf("row%0d stall_cnt", k), 32'(dut.stall_cnt), 32'(t.cnt));
    endtask

    initial begin
        int  n;
        logic seen;

        // Columns: rst, valid, last, full | ready, produce, gvalid, gid, stall_err, chk_cnt, cnt
        // Reset state: nothing granted.
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 0, 1, 3'd0));
        // All four send single-flit packets: grants rotate 0,1,2,3,0.
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 2'd0, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 2'd1, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 2'd2, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 1, 2'd3, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 2'd0, 0, 0, 3'd0));
        // Requester 1: 3-flit packet with 0 and 2 also valid; then 2 is next.
        tbl.push_back(mk(0, 4'b0111, 4'b0000, 0, 4'b0010, 1, 1, 2'd1, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0111, 4'b0000, 0, 4'b0010, 1, 1, 2'd1, 0, 1, 3'd0));
        tbl.push_back(mk(0, 4'b0111, 4'b0010, 0, 4'b0010, 1, 1, 2'd1, 0, 1, 3'd0));
        tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 4'b0100, 1, 1, 2'd2, 0, 0, 3'd0));
        // Requester 3 packet: two idle cycles, five full cycles with the count held, then the last flit.
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 4'b1000, 1, 1, 2'd3, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b1000, 0, 1, 2'd3, 0, 1, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b1000, 0, 1, 2'd3, 0, 1, 3'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b1011, 4'b0000, 1, 4'b0000, 0, 1, 2'd3, 0, 1, 3'd2));
        tbl.push_back(mk(0, 4'b1011, 4'b1000, 0, 4'b1000, 1, 1, 2'd3, 0, 1, 3'd2));
        // Requester 0 locks then stalls: release after 4 idle cycles, one stall_err pulse, 1 next.
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 2'd0, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 1, 2'd0, 0, 1, 3'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0001, 0, 1, 2'd0, 0, 1, 3'd1));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0001, 0, 1, 2'd0, 0, 1, 3'd2));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 4'b0001, 0, 1, 2'd0, 0, 1, 3'd3));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 2'd1, 1, 1, 3'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 2'd0, 0, 0, 3'd0));
        // Full while idle: no write, pointer kept; search from 2 wraps to 0.
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 2'd2, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 4'b0001, 1, 1, 2'd0, 0, 0, 3'd0));
        // Higher-priority arrival during full wins once the buffer drains.
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 1, 2'd2, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b0110, 4'b0110, 0, 4'b0010, 1, 1, 2'd1, 0, 0, 3'd0));
        // Lock on 2, reset mid-packet, then all valid: first grant is 0.
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 1, 2'd2, 0, 0, 3'd0));
        tbl.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 0, 1, 2'd2, 0, 0, 3'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 2'd0, 0, 1, 3'd0));

        drive(0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            drive(k, tbl[k].rst, tbl[k].v, tbl[k].l, tbl[k].full);
            @(negedge clk);
            check_row(k, tbl[k]);
        end

        // Watchdog with wraparound: requester 3 locks, goes silent; bounded wait for stall_err.
        @(posedge clk);
        #1;
        drive(100, 1'b0, 4'b1000, 4'b0000, 1'b0);
        @(negedge clk);
        check("wd lock grant_id", 32'(grant_id), 32'd3);
        check("wd lock produce", 32'(buf_produce), 32'd1);
        @(posedge clk);
        #1;
        drive(101, 1'b0, 4'b0000, 4'b0000, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #2;
            n++;
            seen = stall_err;
        end
        check("wd stall_err seen", 32'(seen), 32'd1);
        check("wd idle cycles", 32'(n), 32'(SM));
        check("wd released grant_valid", 32'(grant_valid), 32'd0);
        @(posedge clk);
        #2;
        check("wd pulse width", 32'(stall_err), 32'd0);
        drive(102, 1'b0, 4'b1111, 4'b1111, 1'b0);
        #1;
        check("wd next grant_id", 32'(grant_id), 32'd0);
        check("wd next ready", 32'(req_ready), 32'b0001);
        check("wd next buf_in", 32'(buf_in), 32'(flit(102, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
